// File: rtl/rd_empty_ctrl.sv
// Read-domain status controller: syncs the Gray write pointer, derives empty/almost-empty/level,
// and gates rd_req into rd_en. Optional sticky underflow flag via RD_UNDERFLOW_DET_EN.
module rd_empty_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 2
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
   input  logic [ADDR_WIDTH:0]   rd_ptr_bin,
   input  logic                  rd_req,
   input  logic                  underflow_clr,
   output logic                  rd_en,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  rd_underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [PW-1:0] wq_q [SYNC_STAGES];
   logic [PW-1:0] wr_bin_sync;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] level_d;
   logic          empty_d;
   logic          ae_d;
   logic          rd_empty_q;
   logic          rd_ae_q;
   logic [PW-1:0] rd_level_q;

   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) wq_q[i] <= '0;
      end else begin
         wq_q[0] <= wr_ptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) wq_q[i] <= wq_q[i-1];
      end
   end

   // Look ahead to the pointer the handler loads on this edge, so the last read sets empty with no bubble.
   always_comb begin
      rd_en       = rd_req & ~rd_empty_q;
      wr_bin_sync = gray2bin(wq_q[SYNC_STAGES-1]);
      rd_ptr_nxt  = rd_ptr_bin + {{(PW-1){1'b0}}, rd_en};
      level_d     = wr_bin_sync - rd_ptr_nxt;
      empty_d     = (bin2gray(rd_ptr_nxt) == wq_q[SYNC_STAGES-1]);
      ae_d        = (level_d <= AE_T);
   end

   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         rd_empty_q <= 1'b1;
         rd_ae_q    <= 1'b1;
         rd_level_q <= '0;
      end else begin
         rd_empty_q <= empty_d;
         rd_ae_q    <= ae_d;
         rd_level_q <= level_d;
      end
   end

   assign rd_empty        = rd_empty_q;
   assign rd_almost_empty = rd_ae_q;
   assign rd_level        = rd_level_q;

`ifdef RD_UNDERFLOW_DET_EN
   logic underflow_q;
   logic underflow_d;

   // Set has priority over clear.
   always_comb begin
      underflow_d = underflow_q;
      if (underflow_clr)          underflow_d = 1'b0;
      if (rd_req && rd_empty_q)   underflow_d = 1'b1;
   end

   always_ff @(posedge rd_clk) begin
      if (!rst_n) underflow_q <= 1'b0;
      else        underflow_q <= underflow_d;
   end

   assign rd_underflow = underflow_q;
`else
   logic unused_clr;
   assign unused_clr   = underflow_clr;
   assign rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Directed bench for rd_empty_ctrl with a behavioural read pointer handler driven by rd_en.
module tb_rd_empty_ctrl;

   localparam int AW = 4;
`ifdef RD_UNDERFLOW_DET_EN
   localparam logic UF_EN = 1'b1;
`else
   localparam logic UF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW:0]   wr_ptr_gray;
   logic [AW:0]   rd_ptr;
   logic          rd_req;
   logic          underflow_clr;
   logic          rd_en;
   logic          rd_empty;
   logic          rd_almost_empty;
   logic [AW:0]   rd_level;
   logic          rd_underflow;
   logic          ld;
   logic [AW:0]   ld_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rd_empty_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
      .rd_clk         (clk),
      .rst_n          (rst_n),
      .wr_ptr_gray    (wr_ptr_gray),
      .rd_ptr_bin     (rd_ptr),
      .rd_req         (rd_req),
      .underflow_clr  (underflow_clr),
      .rd_en          (rd_en),
      .rd_empty       (rd_empty),
      .rd_almost_empty(rd_almost_empty),
      .rd_level       (rd_level),
      .rd_underflow   (rd_underflow)
   );

   // Read pointer handler, reset in the same window, with a preload port for the wrap/full steps.
   always_ff @(posedge clk) begin
      if (!rst_n)  rd_ptr <= '0;
      else if (ld) rd_ptr <= ld_val;
      else         rd_ptr <= rd_ptr + {{AW{1'b0}}, rd_en};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_ptr_gray = 5'b00011; rd_req = 1'b1; underflow_clr = 1'b0;
      ld = 1'b0; ld_val = '0;

      // 1. Reset with request and a nonzero write pointer present
      repeat (3) tick();
      chk("rst_empty", rd_empty, 1);
      chk("rst_ae", rd_almost_empty, 1);
      chk("rst_level", rd_level, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_uf", rd_underflow, 0);

      wr_ptr_gray = 5'b00000; rd_req = 1'b0; rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_empty", rd_empty, 1);
      chk("idle_uf", rd_underflow, 0);

      // 2. Sync latency
      wr_ptr_gray = 5'b00001;
      tick(); chk("sync_e1", rd_empty, 1);
      tick(); chk("sync_e2", rd_empty, 1);
      tick(); chk("sync_e3", rd_empty, 0);
      chk("sync_level", rd_level, 1);
      chk("sync_ae", rd_almost_empty, 1);

      // 3. Drain three words
      wr_ptr_gray = 5'b00010;
      repeat (3) tick();
      chk("drain_lvl3", rd_level, 3);
      chk("drain_ae3", rd_almost_empty, 0);
      rd_req = 1'b1; #1;
      chk("drain_en0", rd_en, 1);
      tick();
      chk("drain_lvl2", rd_level, 2);
      chk("drain_ae2", rd_almost_empty, 1);
      chk("drain_en1", rd_en, 1);
      tick();
      chk("drain_lvl1", rd_level, 1);
      chk("drain_en2", rd_en, 1);
      tick();
      chk("drain_lvl0", rd_level, 0);
      chk("drain_ptr3", rd_ptr, 3);
      chk("drain_empty", rd_empty, 1);
      chk("drain_en3", rd_en, 0);
      chk("drain_uf0", rd_underflow, 0);
      tick();
      chk("drain_uf1", rd_underflow, UF_EN);
      chk("drain_ptr_hold", rd_ptr, 3);

      // 6. Underflow clear: set beats clear, then clear alone
      underflow_clr = 1'b1;
      tick(); chk("clr_set_wins", rd_underflow, UF_EN);
      rd_req = 1'b0;
      tick(); chk("clr_only", rd_underflow, 0);
      underflow_clr = 1'b0;

      // 4. Wrap: pointer 31, write pointer binary 1
      ld = 1'b1; ld_val = 5'd31; wr_ptr_gray = 5'b00001;
      tick(); ld = 1'b0;
      repeat (2) tick();
      chk("wrap_level", rd_level, 2);
      chk("wrap_empty0", rd_empty, 0);
      rd_req = 1'b1;
      tick();
      chk("wrap_ptr0", rd_ptr, 0);
      chk("wrap_level1", rd_level, 1);
      tick();
      chk("wrap_ptr1", rd_ptr, 1);
      chk("wrap_empty1", rd_empty, 1);
      chk("wrap_en", rd_en, 0);
      rd_req = 1'b0;

      // 5. Full: write pointer binary 16, read pointer 0
      ld = 1'b1; ld_val = 5'd0; wr_ptr_gray = 5'b11000;
      tick(); ld = 1'b0;
      repeat (2) tick();
      chk("full_level", rd_level, 16);
      chk("full_ae", rd_almost_empty, 0);
      chk("full_empty", rd_empty, 0);

      // Mid-operation reset with a pending request
      rd_req = 1'b1; rst_n = 1'b0;
      tick();
      chk("mrst_empty", rd_empty, 1);
      chk("mrst_level", rd_level, 0);
      chk("mrst_ae", rd_almost_empty, 1);
      chk("mrst_uf", rd_underflow, 0);
      chk("mrst_en", rd_en, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rd_empty_ctrl.md
# rd_empty_ctrl

Read-domain status controller for the asynchronous FIFO. It synchronizes the Gray-coded write pointer into `rd_clk` and compares it with the read pointer to produce registered empty, almost-empty and fill-level flags. It also gates the consumer's read request into the `rd_en` strobe that advances the read pointer handler. It sits between the write-pointer crossing and the read pointer handler, and its `rd_en` drives that handler directly.

## Interface
- `ADDR_WIDTH`, 4: FIFO address bits; all pointers are ADDR_WIDTH+1 bits.
- `SYNC_STAGES`, 2: flops in the write-pointer synchronizer; legal values are ≥2.
- `AE_THRESH`, 2: almost-empty asserts when the fill level is ≤ this value; legal range 0..2^ADDR_WIDTH.

- `rd_clk` in 1: read-domain clock; all state is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low, sampled on `rd_clk`.
- `wr_ptr_gray` in ADDR_WIDTH+1: Gray write pointer from the write domain; asynchronous to `rd_clk`.
- `rd_ptr_bin` in ADDR_WIDTH+1: registered binary read pointer from the read pointer handler.
- `rd_req` in 1: consumer read request.
- `underflow_clr` in 1: clears the sticky underflow flag.
- `rd_en` out 1: `rd_req & ~rd_empty`, combinational; this is the pointer-handler increment.
- `rd_empty` out 1: registered empty flag.
- `rd_almost_empty` out 1: registered; high when level ≤ `AE_THRESH`.
- `rd_level` out ADDR_WIDTH+1: registered fill level, range 0..2^ADDR_WIDTH.
- `rd_underflow` out 1: sticky flag; set on a request while empty.

## Operation
- **Synchronizer.** `wr_ptr_gray` passes through `SYNC_STAGES` flops (`wq[0..N-1]`) with no logic between stages. `wq[N-1]` is Gray-to-binary converted: bit MSB = g[MSB], and each lower bit = b[i+1] ^ g[i].
- **Next read pointer.** `rd_ptr_nxt = rd_ptr_bin + rd_en`, computed mod 2^(ADDR_WIDTH+1). This matches the value the handler loads on the same edge.
- **Empty.** `rd_empty <= (bin2gray(rd_ptr_nxt) == wq[N-1])`.
- **Level.** `rd_level <= wr_bin_sync - rd_ptr_nxt`, computed mod 2^(ADDR_WIDTH+1).
- **Almost-empty.** `rd_almost_empty <= (level_nxt <= AE_THRESH)`.
- **Read gating.** `rd_en` is never high while `rd_empty` = 1, so the read pointer cannot overtake the write pointer.
- **Wrap-around.** All pointer arithmetic is modular. The extra MSB distinguishes full (level = 2^ADDR_WIDTH) from empty (level = 0).
- **Underflow.** `rd_req` = 1 while `rd_empty` = 1 sets `rd_underflow` on the next edge. `underflow_clr` clears it. If set and clear occur in the same cycle, set wins.
- **Reset values.** During reset (`rst_n` = 0 at an edge):
  - `wq[*]` = 0
  - `rd_empty` = 1
  - `rd_almost_empty` = 1
  - `rd_level` = 0
  - `rd_underflow` = 0

  `rd_en` = 0 for as long as `rd_empty` = 1. A reset asserted mid-operation takes effect on the next edge regardless of `rd_req`, and `rd_req` during reset never sets underflow.
- **Pointer handler reset.** The read pointer handler must be reset in the same window, so that its pointer is also 0 when this block leaves reset.

## Timing
- **Write to empty deassert.** `wr_ptr_gray` changes and then stays stable. `wq[N-1]` updates after `SYNC_STAGES` edges, and `rd_empty`/`rd_level` update after `SYNC_STAGES`+1 edges. With the defaults this is 3 edges.
- **Last-word read.** With level = 1 and `rd_req` = 1, `rd_empty` rises on the same edge the handler increments its pointer. There is no extra bubble, and `rd_en` is 0 in the following cycle.
- **Level lag.** `rd_level` is pessimistic by up to `SYNC_STAGES`+1 cycles of writes. It is exact with respect to reads.
- **Back-to-back reads.** Sustained `rd_req` yields one `rd_en` per cycle until empty.
- **Critical path.** `rd_req` → `rd_en` → adder → Gray compare → `rd_empty` D-input, all within one `rd_clk` cycle.

## Configuration
- `RD_UNDERFLOW_DET_EN`: when defined, the underflow logic is built as described under Operation.
- When undefined, `rd_underflow` is tied to 0, `underflow_clr` is ignored, and no flop is inferred.
- Empty, level and gating behaviour are identical in both builds.

## Test plan
The bench uses ADDR_WIDTH=4, SYNC_STAGES=2, AE_THRESH=2 and instantiates the read pointer handler driven by `rd_en`.

1. **Reset.** Hold `rst_n`=0 for 3 edges with `wr_ptr_gray`=5'b00011 and `rd_req`=1. Required: `rd_empty`=1, `rd_almost_empty`=1, `rd_level`=0, `rd_en`=0, `rd_underflow`=0.
2. **Sync latency.** After reset, change `wr_ptr_gray` from 0 to 5'b00001. Required: `rd_empty` stays 1 for 2 edges and falls on the 3rd; `rd_level`=1; `rd_almost_empty`=1.
3. **Drain.** Set `wr_ptr_gray`=5'b00010 (binary 3), read pointer 0, hold `rd_req`=1. Required:
   - `rd_en` high for exactly 3 cycles.
   - `rd_level` goes 3→2→1→0.
   - `rd_almost_empty` rises at level 2.
   - `rd_empty` rises on the edge the pointer reaches 3.
   - `rd_underflow` sets one edge later.
4. **Wrap.** Preload read pointer 31 and `wr_ptr_gray`=5'b00001 (binary 1). Required: `rd_level`=2; two reads bring the pointer to 1 with `rd_empty`=1.
5. **Full.** Set `wr_ptr_gray`=5'b11000 (binary 16) with read pointer 0. Required: `rd_level`=16, `rd_almost_empty`=0, `rd_empty`=0.
6. **Underflow clear.** With `rd_underflow`=1 and the FIFO empty:
   - `underflow_clr`=1 with `rd_req`=1 → `rd_underflow` stays 1.
   - `underflow_clr`=1 with `rd_req`=0 → `rd_underflow`=0 next edge.
   - In a build without `RD_UNDERFLOW_DET_EN`, `rd_underflow` stays 0 throughout.
